// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: arctangent table, quadrant constants and FSM states.
package cordic_pkg;

   // atan(2^-i) scaled so that 2^32 is a full turn, rounded to nearest
   localparam int unsigned ATAN_N     = 31;
   localparam int unsigned ATAN_IDX_W = 5;

   localparam logic [31:0] ATAN_TABLE [ATAN_N] = '{
      32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
      32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
      32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
      32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
      32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
      32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
      32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
      32'h0000_0003, 32'h0000_0001, 32'h0000_0001
   };

   localparam logic [31:0] QTR_POS = 32'h4000_0000;  // +90 degrees
   localparam logic [31:0] QTR_NEG = 32'hC000_0000;  // -90 degrees

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } cordic_state_e;

endpackage

// File: rtl/cordic_vec_step.sv
// One vectoring-mode CORDIC micro-rotation: rotates (x, y) toward the positive x axis.
module cordic_vec_step #(
   parameter int unsigned W  = 18,
   parameter int unsigned SW = 5
) (
   input  logic signed [W-1:0] x,
   input  logic signed [W-1:0] y,
   input  logic        [31:0]  z,
   input  logic        [SW-1:0] shift,
   input  logic        [31:0]  atan,
   output logic signed [W-1:0] x_nx,
   output logic signed [W-1:0] y_nx,
   output logic        [31:0]  z_nx
);

   logic signed [W-1:0] x_sh;
   logic signed [W-1:0] y_sh;

   // Rotation direction follows the sign of y; both shifts use the pre-update values
   always_comb begin
      x_sh = x >>> shift;
      y_sh = y >>> shift;
      if (!y[W-1]) begin
         x_nx = x + y_sh;
         y_nx = y - x_sh;
         z_nx = z + atan;
      end else begin
         x_nx = x - y_sh;
         y_nx = y + x_sh;
         z_nx = z - atan;
      end
   end

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: (Xin, Yin) -> gain-scaled magnitude and 32-bit phase.
// One shared micro-rotation stage is reused once per clock, valid/ready on both sides.
module cordic_vector
   import cordic_pkg::*;
#(
   parameter int unsigned XY_SZ = 16
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [XY_SZ-1:0] Xin,
   input  logic signed [XY_SZ-1:0] Yin,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [XY_SZ+1:0] mag,
   output logic        [31:0]      phase
);

   localparam int unsigned W  = XY_SZ + 2;
   localparam int unsigned IW = $clog2(XY_SZ);
   localparam logic [IW-1:0] LAST_ITER = IW'(XY_SZ - 2);

   cordic_state_e state_q, state_d;

   logic        [IW-1:0]         iter_q;
   logic        [ATAN_IDX_W-1:0] iter_idx;
   logic signed [W-1:0]          x_q, y_q, x_ld, y_ld, x_nx, y_nx;
   logic signed [W-1:0]          xin_ext, yin_ext;
   logic        [31:0]           z_q, z_ld, z_nx;
   logic                         zero_q;
   logic signed [W-1:0]          mag_q;
   logic        [31:0]           phase_q;
   logic                         accept;

   assign accept   = in_valid && (state_q == StIdle);
   assign iter_idx = ATAN_IDX_W'(iter_q);

   // Next state and handshake outputs; DONE->IDLE never accepts in the same cycle
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) state_d = StRun;
         end
         StRun: begin
            if (iter_q == LAST_ITER) state_d = StDone;
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= StIdle;
      else          state_q <= state_d;
   end

   // Pre-rotation into the right half-plane; widen first so negating -2^(XY_SZ-1) is safe
   always_comb begin
      xin_ext = {{2{Xin[XY_SZ-1]}}, Xin};
      yin_ext = {{2{Yin[XY_SZ-1]}}, Yin};
      x_ld    = xin_ext;
      y_ld    = yin_ext;
      z_ld    = '0;
      if (Xin[XY_SZ-1]) begin
         if (!Yin[XY_SZ-1]) begin
            x_ld = yin_ext;
            y_ld = -xin_ext;
            z_ld = QTR_POS;
         end else begin
            x_ld = -yin_ext;
            y_ld = xin_ext;
            z_ld = QTR_NEG;
         end
      end
   end

   cordic_vec_step #(
      .W  (W),
      .SW (ATAN_IDX_W)
   ) u_step (
      .x     (x_q),
      .y     (y_q),
      .z     (z_q),
      .shift (iter_idx),
      .atan  (ATAN_TABLE[iter_idx]),
      .x_nx  (x_nx),
      .y_nx  (y_nx),
      .z_nx  (z_nx)
   );

   // Datapath: load on accept, iterate in RUN, capture results on the DONE entry edge
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         iter_q  <= '0;
         zero_q  <= 1'b0;
         mag_q   <= '0;
         phase_q <= '0;
      end else if (accept) begin
         x_q    <= x_ld;
         y_q    <= y_ld;
         z_q    <= z_ld;
         iter_q <= '0;
         zero_q <= (Xin == '0) && (Yin == '0);
      end else if (state_q == StRun) begin
         x_q    <= x_nx;
         y_q    <= y_nx;
         z_q    <= z_nx;
         iter_q <= iter_q + IW'(1);
         if (iter_q == LAST_ITER) begin
            mag_q   <= x_nx;
            // Angle of the zero vector is undefined; report 0 instead of the accumulated z
            phase_q <= zero_q ? '0 : z_nx;
         end
      end
   end

   assign mag   = mag_q;
   assign phase = phase_q;

endmodule
